// File: rtl/pipe_skid_reg_pkg.sv
// pipe_skid_reg_pkg: state encoding shared by elastic stage registers
package pipe_skid_reg_pkg;
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_BUSY  = 2'b01,
      ST_FULL  = 2'b11
   } state_t;
endpackage

// File: rtl/dff_en_l.sv
// dff_en_l: enable flip-flop with asynchronous active-low clear
module dff_en_l #(
   parameter int W = 1
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic         en_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);
   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) q_o <= '0;
      else if (en_i) q_o <= d_i;
endmodule

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: elastic stage register with two-entry skid buffer and flush
// Optional stall counter port enabled by defining PIPE_SKID_PERF_EN.
module pipe_skid_reg
   import pipe_skid_reg_pkg::*;
#(
   parameter int DW = 32
`ifdef PIPE_SKID_PERF_EN
  ,parameter int CNT_W = 16
`endif
) (
   input  logic          clk_i,
   input  logic          rst_n_i,
   input  logic          flush_i,
   input  logic          in_valid_i,
   output logic          in_ready_o,
   input  logic [DW-1:0] in_data_i,
   output logic          out_valid_o,
   input  logic          out_ready_i,
   output logic [DW-1:0] out_data_o
`ifdef PIPE_SKID_PERF_EN
  ,output logic [CNT_W-1:0] stall_cnt_o
`endif
);
   state_t        r_state;
   logic [DW-1:0] w_skid;
   logic          w_in_fire, w_out_fire, w_main_en, w_skid_en;
   // Handshake outputs are raw state bits, so no input reaches an output combinationally
   assign in_ready_o  = ~r_state[1];
   assign out_valid_o = r_state[0];
   assign w_in_fire   = in_valid_i & in_ready_o;
   assign w_out_fire  = out_valid_o & out_ready_i;
   assign w_main_en   = ~flush_i & ((r_state == ST_FULL) ? w_out_fire
                                    : w_in_fire & (~out_valid_o | w_out_fire));
   assign w_skid_en   = ~flush_i & (r_state == ST_BUSY) & w_in_fire & ~w_out_fire;

   dff_en_l #(.W(DW)) u_main (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .en_i    (w_main_en),
      .d_i     ((r_state == ST_FULL) ? w_skid : in_data_i),
      .q_o     (out_data_o)
   );

   dff_en_l #(.W(DW)) u_skid (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .en_i    (w_skid_en),
      .d_i     (in_data_i),
      .q_o     (w_skid)
   );

   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) r_state <= ST_EMPTY;
      else if (flush_i) r_state <= ST_EMPTY;
      else
         case (r_state)
            ST_EMPTY: if (w_in_fire) r_state <= ST_BUSY;
            ST_BUSY:
               if (w_in_fire & ~w_out_fire) r_state <= ST_FULL;
               else if (~w_in_fire & w_out_fire) r_state <= ST_EMPTY;
            ST_FULL:  if (w_out_fire) r_state <= ST_BUSY;
            default:  r_state <= ST_EMPTY;
         endcase

`ifdef PIPE_SKID_PERF_EN
   logic [CNT_W-1:0] r_stall_cnt;
   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) r_stall_cnt <= '0;
      else if (out_valid_o & ~out_ready_i & ~&r_stall_cnt) r_stall_cnt <= r_stall_cnt + 1'b1;
   assign stall_cnt_o = r_stall_cnt;
`endif
endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: table-driven handshake vectors plus FIFO scoreboard for data
module tb_pipe_skid_reg;
   logic        clk_i = 1'b0;
   logic        rst_n_i = 1'b0;
   logic        flush_i = 1'b0;
   logic        in_valid_i = 1'b0;
   logic        in_ready_o;
   logic [31:0] in_data_i = '0;
   logic        out_valid_o;
   logic        out_ready_i = 1'b0;
   logic [31:0] out_data_o;
`ifdef PIPE_SKID_PERF_EN
   logic [3:0]  stall_cnt_o;
   int          stall_m = 0;
`endif

   int n_chk = 0;
   int n_pass = 0;
   logic [31:0] q[$];

   typedef struct {
      logic        v;
      logic [31:0] d;
      logic        r;
      logic        f;
      logic        ev;
      logic        er;
   } vec_t;
   vec_t tbl[18];

   always #5 clk_i = ~clk_i;

   pipe_skid_reg #(
      .DW(32)
`ifdef PIPE_SKID_PERF_EN
     ,.CNT_W(4)
`endif
   ) dut (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .flush_i     (flush_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .in_data_i   (in_data_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_data_o  (out_data_o)
`ifdef PIPE_SKID_PERF_EN
     ,.stall_cnt_o (stall_cnt_o)
`endif
   );

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
   endtask

   task automatic check_model();
      chk("out_valid", {31'b0, out_valid_o}, {31'b0, q.size() > 0});
      chk("in_ready", {31'b0, in_ready_o}, {31'b0, q.size() < 2});
      if (q.size() > 0) chk("out_data", out_data_o, q[0]);
`ifdef PIPE_SKID_PERF_EN
      chk("stall_cnt", {28'b0, stall_cnt_o}, stall_m);
`endif
   endtask

   // Drive one cycle, advance the model at the edge, then compare against it
   task automatic step(input logic v, input logic [31:0] d, input logic r, input logic f);
      logic inf, outf;
      in_valid_i  = v;
      in_data_i   = d;
      out_ready_i = r;
      flush_i     = f;
      inf  = v & (q.size() < 2);
      outf = (q.size() > 0) & r;
`ifdef PIPE_SKID_PERF_EN
      if (q.size() > 0 && !r && stall_m < 15) stall_m++;
`endif
      @(posedge clk_i);
      #1;
      if (f) q.delete();
      else begin
         if (outf) void'(q.pop_front());
         if (inf) q.push_back(d);
      end
      check_model();
   endtask

   initial begin
      tbl[0]  = '{1'b1, 32'h11, 1'b1, 1'b0, 1'b1, 1'b1};
      tbl[1]  = '{1'b1, 32'h22, 1'b1, 1'b0, 1'b1, 1'b1};
      tbl[2]  = '{1'b1, 32'h33, 1'b1, 1'b0, 1'b1, 1'b1};
      tbl[3]  = '{1'b0, 32'hDEAD, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[4]  = '{1'b1, 32'hA0, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[5]  = '{1'b1, 32'hB0, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[6]  = '{1'b1, 32'hC0, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[7]  = '{1'b1, 32'hC0, 1'b1, 1'b0, 1'b1, 1'b1};
      tbl[8]  = '{1'b1, 32'hC0, 1'b1, 1'b0, 1'b1, 1'b1};
      tbl[9]  = '{1'b0, 32'hBEEF, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[10] = '{1'b1, 32'h5, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[11] = '{1'b1, 32'h6, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[12] = '{1'b1, 32'h7, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[13] = '{1'b0, 32'h7, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[14] = '{1'b1, 32'h8, 1'b1, 1'b0, 1'b1, 1'b1};
      tbl[15] = '{1'b1, 32'h9, 1'b1, 1'b1, 1'b0, 1'b1};
      tbl[16] = '{1'b0, 32'h9, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[17] = '{1'b1, 32'h4C, 1'b0, 1'b0, 1'b1, 1'b1};

      #22 rst_n_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 32'h0, 1'b0, 1'b0);
         chk("idle_data", out_data_o, 32'h0);
      end

      for (int i = 0; i < 18; i++) begin
         step(tbl[i].v, tbl[i].d, tbl[i].r, tbl[i].f);
         chk($sformatf("vec%0d_valid", i), {31'b0, out_valid_o}, {31'b0, tbl[i].ev});
         chk($sformatf("vec%0d_ready", i), {31'b0, in_ready_o}, {31'b0, tbl[i].er});
      end

      // Stage is BUSY holding 0x4C; reset asynchronously between edges
      #3 rst_n_i = 1'b0;
      #1;
      chk("arst_valid", {31'b0, out_valid_o}, 32'h0);
      chk("arst_ready", {31'b0, in_ready_o}, 32'h1);
      chk("arst_data", out_data_o, 32'h0);
      q.delete();
`ifdef PIPE_SKID_PERF_EN
      stall_m = 0;
      chk("arst_stall", {28'b0, stall_cnt_o}, 32'h0);
`endif
      in_valid_i = 1'b0;
      #2 rst_n_i = 1'b1;
      step(1'b1, 32'h9, 1'b0, 1'b0);
      chk("post_rst_data", out_data_o, 32'h9);

      for (int i = 0; i < 20; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
      step(1'b1, 32'h77, 1'b0, 1'b1);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      step(1'b1, 32'h12, 1'b1, 1'b0);
      step(1'b1, 32'h34, 1'b1, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
